// File: rtl/can_pkg.sv
// Shared CAN 2.0A definitions: receiver states, CRC polynomial, error codes, field widths.
package can_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_SOF,
        ST_ID,
        ST_RTR,
        ST_IDE,
        ST_R0,
        ST_DLC,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK_SLOT,
        ST_ACK_DEL,
        ST_EOF
    } can_state_e;

    localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

    localparam logic [1:0] ERR_STUFF = 2'd0;
    localparam logic [1:0] ERR_CRC   = 2'd1;
    localparam logic [1:0] ERR_FORM  = 2'd2;
    localparam logic [1:0] ERR_DLC   = 2'd3;

    localparam int ID_W   = 11;
    localparam int DLC_W  = 4;
    localparam int CRC_W  = 15;
    localparam int EOF_W  = 7;
    localparam int IDLE_W = 11;

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 accumulator, shared by the transmit and receive paths.
module can_crc15
    import can_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [14:0] crc
);

    logic [14:0] crc_q;
    logic [14:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (bit_en) begin
            crc_d = {crc_q[13:0], 1'b0};
            if (bit_in ^ crc_q[14]) begin
                crc_d = crc_d ^ CAN_CRC_POLY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/can_rx.sv
// CAN 2.0A standard-frame receiver: bit timing, destuffing, decode, CRC/form/DLC checks.
// Optional ACK drive is built only when CAN_RX_ACK_EN is defined.
module can_rx
    import can_pkg::*;
#(
    parameter int CLKS_PER_BIT = 800,
    parameter int SAMPLE_POINT = 560
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [10:0] filter_address,
    input  logic [10:0] filter_mask,
    output logic        tx,
    output logic [10:0] rx_address,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_error,
    output logic [1:0]  rx_err_code
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT - 1);

    logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sampled_q, sampled_d;
    can_state_e       state_q, state_d, pend_q, pend_d;
    logic [5:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       run_q, run_d;
    logic             last_q, last_d;
    logic [3:0]       idle_cnt_q, idle_cnt_d;
    logic [10:0]      id_q, id_d;
    logic             rtr_q, rtr_d, ide_q, ide_d;
    logic [3:0]       dlc_q, dlc_d;
    logic [31:0]      data_q, data_d;
    logic [14:0]      crc_rx_q, crc_rx_d;
    logic [10:0]      rx_address_q, rx_address_d;
    logic             rx_rtr_q, rx_rtr_d;
    logic [3:0]       rx_dlc_q, rx_dlc_d;
    logic [31:0]      rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d, rx_error_q, rx_error_d;
    logic [1:0]       rx_err_code_q, rx_err_code_d;

    logic        crc_clr, crc_en;
    logic [14:0] crc_calc;
    logic        ack_drive;
    logic        fall, resync, sample_evt, smp, in_stuff, err, accept;
    logic [1:0]  err_code;
    logic [5:0]  data_last;

    can_crc15 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .bit_en (crc_en),
        .bit_in (smp),
        .crc    (crc_calc)
    );

`ifdef CAN_RX_ACK_EN
    logic tx_q, tx_d;
    // Only a CRC-clean frame reaches ACK_SLOT, so the slot itself gates the drive.
    assign tx_d      = (state_d != ST_ACK_SLOT);
    assign ack_drive = ~tx_q;
    assign tx        = tx_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_q <= 1'b1;
        else     tx_q <= tx_d;
    end
`else
    assign ack_drive = 1'b0;
    assign tx        = 1'b1;
`endif

    always_comb begin
        rx_s1_d       = rx;
        rx_s2_d       = rx_s1_q;
        rx_prev_d     = rx_s2_q;
        cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        sampled_d     = sampled_q;
        state_d       = state_q;
        pend_d        = pend_q;
        bit_idx_d     = bit_idx_q;
        run_d         = run_q;
        last_d        = last_q;
        idle_cnt_d    = idle_cnt_q;
        id_d          = id_q;
        rtr_d         = rtr_q;
        ide_d         = ide_q;
        dlc_d         = dlc_q;
        data_d        = data_q;
        crc_rx_d      = crc_rx_q;
        rx_address_d  = rx_address_q;
        rx_rtr_d      = rx_rtr_q;
        rx_dlc_d      = rx_dlc_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_error_d    = 1'b0;
        rx_err_code_d = rx_err_code_q;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;
        err           = 1'b0;
        err_code      = ERR_STUFF;

        smp        = rx_s2_q;
        fall       = rx_prev_q & ~rx_s2_q;
        // Our own ACK edge must not resync us, or the slot would stretch.
        resync     = fall & ~ack_drive;
        sample_evt = (cnt_q == CNT_SAMPLE) && !resync;
        in_stuff   = state_q inside {ST_SOF, ST_ID, ST_RTR, ST_IDE, ST_R0,
                                     ST_DLC, ST_DATA, ST_CRC, ST_CRC_DEL};
        accept     = ((id_q ^ filter_address) & filter_mask) == 11'd0;
        data_last  = {dlc_q[2:0], 3'b000} - 6'd1;

        if (resync) begin
            cnt_d = '0;
        end

        // Field transitions land on the bit boundary; decisions were made at the sample.
        if (state_q != ST_WAIT_IDLE && state_q != ST_IDLE && sampled_q
                && (cnt_q == CNT_LAST || resync)) begin
            state_d   = pend_q;
            sampled_d = 1'b0;
        end

        case (state_q)
            ST_WAIT_IDLE: begin
                if (sample_evt) begin
                    if (!smp) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == 4'(IDLE_W - 1)) begin
                        idle_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (fall) begin
                    cnt_d     = '0;
                    state_d   = ST_SOF;
                    pend_d    = ST_SOF;
                    sampled_d = 1'b0;
                    bit_idx_d = '0;
                    run_d     = '0;
                    data_d    = '0;
                    crc_clr   = 1'b1;
                end
            end
            default: begin
                if (sample_evt) begin
                    sampled_d = 1'b1;
                    if (in_stuff && run_q == 3'd5) begin
                        if (smp == last_q) begin
                            err      = 1'b1;
                            err_code = ERR_STUFF;
                        end else begin
                            last_d = smp;
                            run_d  = 3'd1;
                        end
                    end else begin
                        if (in_stuff && state_q != ST_CRC_DEL) begin
                            run_d  = (state_q != ST_SOF && smp == last_q) ? run_q + 3'd1 : 3'd1;
                            last_d = smp;
                        end
                        crc_en    = state_q inside {ST_SOF, ST_ID, ST_RTR, ST_IDE,
                                                    ST_R0, ST_DLC, ST_DATA};
                        bit_idx_d = bit_idx_q + 6'd1;
                        case (state_q)
                            ST_SOF: begin
                                bit_idx_d = '0;
                                if (smp) state_d = ST_IDLE;
                                else     pend_d  = ST_ID;
                            end
                            ST_ID: begin
                                id_d = {id_q[9:0], smp};
                                if (bit_idx_q == 6'(ID_W - 1)) begin
                                    bit_idx_d = '0;
                                    pend_d    = ST_RTR;
                                end
                            end
                            ST_RTR: begin
                                rtr_d     = smp;
                                bit_idx_d = '0;
                                pend_d    = ST_IDE;
                            end
                            ST_IDE: begin
                                ide_d     = smp;
                                bit_idx_d = '0;
                                pend_d    = ST_R0;
                            end
                            ST_R0: begin
                                bit_idx_d = '0;
                                pend_d    = ST_DLC;
                            end
                            ST_DLC: begin
                                dlc_d = {dlc_q[2:0], smp};
                                if (bit_idx_q == 6'(DLC_W - 1)) begin
                                    bit_idx_d = '0;
                                    if (dlc_d > 4'd4 || ide_q) begin
                                        err      = 1'b1;
                                        err_code = ERR_DLC;
                                    end else if (rtr_q || dlc_d == 4'd0) begin
                                        pend_d = ST_CRC;
                                    end else begin
                                        pend_d = ST_DATA;
                                    end
                                end
                            end
                            ST_DATA: begin
                                data_d[5'd31 - bit_idx_q[4:0]] = smp;
                                if (bit_idx_q == data_last) begin
                                    bit_idx_d = '0;
                                    pend_d    = ST_CRC;
                                end
                            end
                            ST_CRC: begin
                                crc_rx_d = {crc_rx_q[13:0], smp};
                                if (bit_idx_q == 6'(CRC_W - 1)) begin
                                    bit_idx_d = '0;
                                    pend_d    = ST_CRC_DEL;
                                end
                            end
                            ST_CRC_DEL: begin
                                bit_idx_d = '0;
                                if (crc_rx_q != crc_calc) begin
                                    err      = 1'b1;
                                    err_code = ERR_CRC;
                                end else if (!smp) begin
                                    err      = 1'b1;
                                    err_code = ERR_FORM;
                                end else begin
                                    pend_d = ST_ACK_SLOT;
                                end
                            end
                            ST_ACK_SLOT: begin
                                bit_idx_d = '0;
                                pend_d    = ST_ACK_DEL;
                            end
                            ST_ACK_DEL: begin
                                bit_idx_d = '0;
                                if (!smp) begin
                                    err      = 1'b1;
                                    err_code = ERR_FORM;
                                end else begin
                                    pend_d = ST_EOF;
                                end
                            end
                            ST_EOF: begin
                                if (!smp) begin
                                    err      = 1'b1;
                                    err_code = ERR_FORM;
                                end else if (bit_idx_q == 6'(EOF_W - 1)) begin
                                    bit_idx_d = '0;
                                    state_d   = ST_IDLE;
                                    if (accept) begin
                                        rx_address_d = id_q;
                                        rx_rtr_d     = rtr_q;
                                        rx_dlc_d     = dlc_q;
                                        rx_data_d    = data_q;
                                        rx_valid_d   = 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        if (err) begin
            rx_error_d    = 1'b1;
            rx_err_code_d = err_code;
            rx_valid_d    = 1'b0;
            rx_address_d  = rx_address_q;
            rx_rtr_d      = rx_rtr_q;
            rx_dlc_d      = rx_dlc_q;
            rx_data_d     = rx_data_q;
            state_d       = ST_WAIT_IDLE;
            idle_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            cnt_q         <= '0;
            sampled_q     <= 1'b0;
            state_q       <= ST_WAIT_IDLE;
            pend_q        <= ST_WAIT_IDLE;
            bit_idx_q     <= '0;
            run_q         <= '0;
            last_q        <= 1'b1;
            idle_cnt_q    <= '0;
            id_q          <= '0;
            rtr_q         <= 1'b0;
            ide_q         <= 1'b0;
            dlc_q         <= '0;
            data_q        <= '0;
            crc_rx_q      <= '0;
            rx_address_q  <= '0;
            rx_rtr_q      <= 1'b0;
            rx_dlc_q      <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_error_q    <= 1'b0;
            rx_err_code_q <= '0;
        end else begin
            rx_s1_q       <= rx_s1_d;
            rx_s2_q       <= rx_s2_d;
            rx_prev_q     <= rx_prev_d;
            cnt_q         <= cnt_d;
            sampled_q     <= sampled_d;
            state_q       <= state_d;
            pend_q        <= pend_d;
            bit_idx_q     <= bit_idx_d;
            run_q         <= run_d;
            last_q        <= last_d;
            idle_cnt_q    <= idle_cnt_d;
            id_q          <= id_d;
            rtr_q         <= rtr_d;
            ide_q         <= ide_d;
            dlc_q         <= dlc_d;
            data_q        <= data_d;
            crc_rx_q      <= crc_rx_d;
            rx_address_q  <= rx_address_d;
            rx_rtr_q      <= rx_rtr_d;
            rx_dlc_q      <= rx_dlc_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_error_q    <= rx_error_d;
            rx_err_code_q <= rx_err_code_d;
        end
    end

    assign rx_address  = rx_address_q;
    assign rx_rtr      = rx_rtr_q;
    assign rx_dlc      = rx_dlc_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_error    = rx_error_q;
    assign rx_err_code = rx_err_code_q;

endmodule
